// File: rtl/edf_pkg.sv
// Shared types and helpers for the earliest-deadline-first interrupt arbiter.
package edf_pkg;

  localparam int unsigned DefaultTsWidth = 64;
  localparam int unsigned DefaultNrSrc   = 32;

  function automatic int unsigned id_width(input int unsigned nr_src);
    return (nr_src < 2) ? 1 : $clog2(nr_src);
  endfunction

  localparam int unsigned DefaultIdWidth = id_width(DefaultNrSrc);

  // Node payload for the default configuration; parameterised instances declare a local twin.
  typedef struct packed {
    logic                      valid;
    logic [DefaultIdWidth-1:0] id;
    logic [DefaultTsWidth-1:0] dl;
  } edf_node_t;

endpackage

// File: rtl/edf_cmp_node.sv
// Two-input EDF select: earlier deadline wins, the a side wins ties.
module edf_cmp_node
  import edf_pkg::*;
#(
  parameter int unsigned IdWidth = DefaultIdWidth,
  parameter int unsigned TsWidth = DefaultTsWidth
) (
  input  logic               a_valid,
  input  logic [IdWidth-1:0] a_id,
  input  logic [TsWidth-1:0] a_dl,
  input  logic               b_valid,
  input  logic [IdWidth-1:0] b_id,
  input  logic [TsWidth-1:0] b_dl,
  output logic               y_valid,
  output logic [IdWidth-1:0] y_id,
  output logic [TsWidth-1:0] y_dl
);

  logic pick_b;

  always_comb begin
    pick_b = 1'b0;
    if (!a_valid) begin
      pick_b = b_valid;
    end else if (b_valid && (b_dl < a_dl)) begin
      pick_b = 1'b1;
    end
    y_valid = a_valid | b_valid;
    y_id    = pick_b ? b_id : a_id;
    y_dl    = pick_b ? b_dl : a_dl;
  end

endmodule

// File: rtl/edf_arbiter.sv
// EDF interrupt arbiter: registered comparison tree over all sources, claim decode
// and a post-claim lockout that hides the stale winner until the tree has flushed.
module edf_arbiter
  import edf_pkg::*;
#(
  parameter int unsigned NrSrc   = 32,
  parameter int unsigned TsWidth = DefaultTsWidth,
  parameter int unsigned IdWidth = id_width(NrSrc)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [TsWidth-1:0] dl_i [NrSrc],
  input  logic [NrSrc-1:0]   ip_i,
  input  logic               claim_i,
  output logic               irq_o,
  output logic [IdWidth-1:0] irq_id_o,
  output logic [TsWidth-1:0] irq_dl_o,
  output logic [NrSrc-1:0]   claim_o
);

  localparam int unsigned Levels = $clog2(NrSrc);
  localparam int unsigned NrLeaf = 1 << Levels;
  localparam int unsigned LockW  = $clog2(Levels + 2);

  typedef struct packed {
    logic               valid;
    logic [IdWidth-1:0] id;
    logic [TsWidth-1:0] dl;
  } node_t;

  // Heap layout: node 1 is the root, node k has children 2k and 2k+1.
  node_t            leaf   [NrLeaf];
  node_t            node_d [1:NrLeaf-1];
  node_t            node_q [1:NrLeaf-1];
  logic [LockW-1:0] lock_cnt;

  for (genvar i = 0; i < NrLeaf; i++) begin : g_leaf
    if (i < NrSrc) begin : g_src
      assign leaf[i] = '{valid: ip_i[i], id: IdWidth'(i), dl: dl_i[i]};
    end else begin : g_pad
      assign leaf[i] = '0;
    end
  end

  for (genvar k = 1; k < NrLeaf; k++) begin : g_node
    node_t               a;
    node_t               b;
    logic                y_valid;
    logic [IdWidth-1:0]  y_id;
    logic [TsWidth-1:0]  y_dl;

    if (2 * k >= NrLeaf) begin : g_from_leaf
      assign a = leaf[2*k-NrLeaf];
      assign b = leaf[2*k+1-NrLeaf];
    end else begin : g_from_node
      assign a = node_q[2*k];
      assign b = node_q[2*k+1];
    end

    edf_cmp_node #(
      .IdWidth(IdWidth),
      .TsWidth(TsWidth)
    ) u_cmp (
      .a_valid(a.valid),
      .a_id   (a.id),
      .a_dl   (a.dl),
      .b_valid(b.valid),
      .b_id   (b.id),
      .b_dl   (b.dl),
      .y_valid(y_valid),
      .y_id   (y_id),
      .y_dl   (y_dl)
    );

    assign node_d[k] = '{valid: y_valid, id: y_id, dl: y_dl};
  end

  // Tree registers plus lockout: one cycle for the gateway to drop ip, Levels to flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 1; k < NrLeaf; k++) begin
        node_q[k] <= '0;
      end
      lock_cnt <= '0;
    end else begin
      for (int unsigned k = 1; k < NrLeaf; k++) begin
        node_q[k] <= node_d[k];
      end
      if (claim_i && irq_o) begin
        lock_cnt <= LockW'(Levels + 1);
      end else if (lock_cnt != '0) begin
        lock_cnt <= lock_cnt - LockW'(1);
      end
    end
  end

  assign irq_o    = node_q[1].valid && (lock_cnt == '0);
  assign irq_id_o = node_q[1].id;
  assign irq_dl_o = node_q[1].dl;

  always_comb begin
    claim_o = '0;
    for (int unsigned i = 0; i < NrSrc; i++) begin
      claim_o[i] = claim_i && irq_o && (irq_id_o == IdWidth'(i));
    end
  end

endmodule

// File: tb/tb_edf_arbiter.sv
// Bench for edf_arbiter: directed scenarios on 32- and 5-source instances plus
// randomized traffic checked against a delayed earliest-deadline reference.
module tb_edf_arbiter;

  localparam int unsigned N   = 32;
  localparam int unsigned IW  = 5;
  localparam int unsigned L   = 5;
  localparam int unsigned N5  = 5;
  localparam int unsigned IW5 = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [63:0]   dl [N];
  logic [N-1:0]  ip;
  logic          claim;
  logic          irq;
  logic [IW-1:0] irq_id;
  logic [63:0]   irq_dl;
  logic [N-1:0]  claim_o;

  logic [63:0]    dl5 [N5];
  logic [N5-1:0]  ip5;
  logic           claim5;
  logic           irq5;
  logic [IW5-1:0] irq_id5;
  logic [63:0]    irq_dl5;
  logic [N5-1:0]  claim_o5;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  edf_arbiter #(.NrSrc(N), .TsWidth(64)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .dl_i(dl), .ip_i(ip), .claim_i(claim),
    .irq_o(irq), .irq_id_o(irq_id), .irq_dl_o(irq_dl), .claim_o(claim_o)
  );

  edf_arbiter #(.NrSrc(N5), .TsWidth(64)) u_dut5 (
    .clk_i(clk), .rst_ni(rst_n), .dl_i(dl5), .ip_i(ip5), .claim_i(claim5),
    .irq_o(irq5), .irq_id_o(irq_id5), .irq_dl_o(irq_dl5), .claim_o(claim_o5)
  );

  // Reference: the root shows the EDF winner of the inputs from L cycles ago,
  // and is hidden until L+2 cycles after an accepted claim.
  typedef struct {
    bit          valid;
    int          id;
    logic [63:0] dl;
  } win_t;

  win_t         hist [$];
  int           t;
  int           last_claim;
  win_t         exp_root;
  bit           exp_irq;
  logic [N-1:0] exp_claim;

  function automatic win_t winner();
    win_t w;
    w.valid = 1'b0;
    w.id    = 0;
    w.dl    = '0;
    for (int i = 0; i < N; i++) begin
      if (ip[i] && (!w.valid || dl[i] < w.dl)) begin
        w.valid = 1'b1;
        w.id    = i;
        w.dl    = dl[i];
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    win_t empty;
    empty.valid = 1'b0;
    empty.id    = 0;
    empty.dl    = '0;
    hist.delete();
    for (int i = 0; i < int'(L); i++) hist.push_back(empty);
    t          = 0;
    last_claim = -100;
  endtask

  task automatic model_step();
    exp_root  = hist.pop_front();
    exp_irq   = exp_root.valid && (t >= last_claim + int'(L) + 2);
    exp_claim = '0;
    if (claim && exp_irq) begin
      exp_claim[exp_root.id] = 1'b1;
      last_claim = t;
    end
    hist.push_back(winner());
    t++;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    claim  = 1'b0;
    claim5 = 1'b0;
  endtask

  task automatic quiesce();
    ip    = '0;
    claim = 1'b0;
    repeat (L + 3) @(negedge clk);
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    claim = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", irq); end
    n_vec++; if (irq_id !== '0) begin n_err++; $display("FAIL rst_id: got %0d want 0", irq_id); end
    n_vec++; if (irq_dl !== '0) begin n_err++; $display("FAIL rst_dl: got %0d want 0", irq_dl); end
    n_vec++; if (claim_o !== '0) begin n_err++; $display("FAIL rst_claim: got %h want 0", claim_o); end
    n_vec++; if (irq5 !== 1'b0) begin n_err++; $display("FAIL rst_irq5: got %b want 0", irq5); end
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      claim = 1'($urandom % 2);
      #1;
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL idle_irq: cyc %0d got %b want 0", c, irq); end
      n_vec++; if (claim_o !== '0) begin n_err++; $display("FAIL idle_claim: cyc %0d got %h want 0", c, claim_o); end
    end
  endtask

  task automatic test_lockout();
    quiesce();
    next_cycle();
    ip[5] = 1'b1; dl[5] = 64'd100;
    ip[9] = 1'b1; dl[9] = 64'd40;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      #1;
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL latency: k=%0d got irq %b want 0", k, irq); end
    end
    next_cycle();
    claim = 1'b1;
    #1;
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL win_irq: got %b want 1", irq); end
    n_vec++; if (irq_id !== 5'd9) begin n_err++; $display("FAIL win_id: got %0d want 9", irq_id); end
    n_vec++; if (irq_dl !== 64'd40) begin n_err++; $display("FAIL win_dl: got %0d want 40", irq_dl); end
    n_vec++; if (claim_o !== 32'h200) begin n_err++; $display("FAIL claim_vec: got %h want 00000200", claim_o); end
    next_cycle();
    #1;
    n_vec++; if (claim_o !== '0) begin n_err++; $display("FAIL claim_pulse: got %h want 0", claim_o); end
    for (int k = 7; k <= 11; k++) begin
      next_cycle();
      if (k == 7) ip[9] = 1'b0;
      #1;
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL lockout: k=%0d got irq %b id %0d want 0", k, irq, irq_id); end
    end
    next_cycle();
    #1;
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL relock_irq: got %b want 1", irq); end
    n_vec++; if (irq_id !== 5'd5) begin n_err++; $display("FAIL relock_id: got %0d want 5", irq_id); end
    n_vec++; if (irq_dl !== 64'd100) begin n_err++; $display("FAIL relock_dl: got %0d want 100", irq_dl); end
  endtask

  task automatic test_tie();
    quiesce();
    next_cycle();
    ip[3]  = 1'b1; dl[3]  = 64'd77;
    ip[12] = 1'b1; dl[12] = 64'd77;
    repeat (4) next_cycle();
    next_cycle();
    claim = 1'b1;
    #1;
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL tie_irq: got %b want 1", irq); end
    n_vec++; if (irq_id !== 5'd3) begin n_err++; $display("FAIL tie_id: got %0d want 3", irq_id); end
    n_vec++; if (claim_o !== 32'h8) begin n_err++; $display("FAIL tie_claim: got %h want 00000008", claim_o); end
    for (int k = 6; k <= 11; k++) begin
      next_cycle();
      if (k == 6) ip[3] = 1'b0;
      #1;
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL tie_lock: k=%0d got %b want 0", k, irq); end
    end
    next_cycle();
    #1;
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL tie_next_irq: got %b want 1", irq); end
    n_vec++; if (irq_id !== 5'd12) begin n_err++; $display("FAIL tie_next_id: got %0d want 12", irq_id); end
    n_vec++; if (irq_dl !== 64'd77) begin n_err++; $display("FAIL tie_next_dl: got %0d want 77", irq_dl); end
  endtask

  task automatic test_nonpow2();
    for (int i = 0; i < int'(N5); i++) dl5[i] = '0;
    ip5 = '0;
    repeat (4) next_cycle();
    #1;
    n_vec++; if (irq5 !== 1'b0) begin n_err++; $display("FAIL np2_idle: got %b want 0", irq5); end
    next_cycle();
    ip5[4] = 1'b1; dl5[4] = 64'd1;
    for (int k = 1; k <= 2; k++) begin
      next_cycle();
      #1;
      n_vec++; if (irq5 !== 1'b0) begin n_err++; $display("FAIL np2_latency: k=%0d got %b want 0", k, irq5); end
    end
    next_cycle();
    claim5 = 1'b1;
    #1;
    n_vec++; if (irq5 !== 1'b1) begin n_err++; $display("FAIL np2_irq: got %b want 1", irq5); end
    n_vec++; if (irq_id5 !== 3'd4) begin n_err++; $display("FAIL np2_id: got %0d want 4", irq_id5); end
    n_vec++; if (irq_dl5 !== 64'd1) begin n_err++; $display("FAIL np2_dl: got %0d want 1", irq_dl5); end
    n_vec++; if (claim_o5 !== 5'b10000) begin n_err++; $display("FAIL np2_claim: got %b want 10000", claim_o5); end
    next_cycle();
    ip5 = '0;
  endtask

  task automatic test_async_reset();
    quiesce();
    next_cycle();
    ip[9] = 1'b1; dl[9] = 64'd40;
    repeat (4) next_cycle();
    next_cycle();
    claim = 1'b1;
    #1;
    n_vec++; if (claim_o !== 32'h200) begin n_err++; $display("FAIL ar_claim: got %h want 00000200", claim_o); end
    next_cycle();
    ip[9] = 1'b0;
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (u_dut.lock_cnt !== '0) begin n_err++; $display("FAIL ar_lock: got %0d want 0", u_dut.lock_cnt); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL ar_irq: got %b want 0", irq); end
    n_vec++; if (irq_id !== '0) begin n_err++; $display("FAIL ar_id: got %0d want 0", irq_id); end
    n_vec++; if (irq_dl !== '0) begin n_err++; $display("FAIL ar_dl: got %0d want 0", irq_dl); end
    ip = '0;
    ip[0] = 1'b1; dl[0] = 64'd0;
    next_cycle();
    claim = 1'b1;
    #1;
    n_vec++; if (claim_o !== '0) begin n_err++; $display("FAIL ar_in_rst_claim: got %h want 0", claim_o); end
    next_cycle();
    rst_n = 1'b1;
    claim = 1'b1;
    #1;
    n_vec++; if (claim_o !== '0) begin n_err++; $display("FAIL ar_glitch: got %h want 0", claim_o); end
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      #1;
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL ar_latency: k=%0d got %b want 0", k, irq); end
    end
    next_cycle();
    #1;
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL ar_after_irq: got %b want 1", irq); end
    n_vec++; if (irq_id !== 5'd0) begin n_err++; $display("FAIL ar_after_id: got %0d want 0", irq_id); end
    n_vec++; if (irq_dl !== 64'd0) begin n_err++; $display("FAIL ar_after_dl: got %0d want 0", irq_dl); end
  endtask

  task automatic test_random();
    bit clr;
    int clr_id;
    int s;
    clr    = 1'b0;
    clr_id = 0;
    quiesce();
    for (int c = 0; c < 600; c++) begin
      next_cycle();
      if (clr) ip[clr_id] = 1'b0;
      if ($urandom % 3 == 0) begin
        s     = int'($urandom % N);
        ip[s] = ~ip[s];
        dl[s] = ($urandom % 4 != 0) ? 64'($urandom % 8) : {$urandom, $urandom};
      end
      claim = ($urandom % 4 == 0);
      model_step();
      clr    = claim && exp_irq;
      clr_id = exp_root.id;
      #1;
      n_vec++; if (irq !== exp_irq) begin n_err++; $display("FAIL rnd_irq: cyc %0d got %b want %b", c, irq, exp_irq); end
      n_vec++; if (claim_o !== exp_claim) begin n_err++; $display("FAIL rnd_claim: cyc %0d got %h want %h", c, claim_o, exp_claim); end
      if (exp_irq) begin
        n_vec++; if (irq_id !== IW'(exp_root.id)) begin n_err++; $display("FAIL rnd_id: cyc %0d got %0d want %0d", c, irq_id, exp_root.id); end
        n_vec++; if (irq_dl !== exp_root.dl) begin n_err++; $display("FAIL rnd_dl: cyc %0d got %0d want %0d", c, irq_dl, exp_root.dl); end
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ip     = '0;
    claim  = 1'b0;
    ip5    = '0;
    claim5 = 1'b0;
    for (int i = 0; i < int'(N); i++) dl[i] = '0;
    for (int i = 0; i < int'(N5); i++) dl5[i] = '0;
    model_reset();
    test_reset();
    test_lockout();
    test_tie();
    test_nonpow2();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
